// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Holds the FSM state enum, ALUControl codes and datapath width defaults.
package alu_seq_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_CTRL_W = 4;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      EXEC,
      WRITE,
      ERR
   } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALUControl legality check, shared with the front end.
// Ports: opcode (in, CTRL_W) -> legal (out, 1 when a supported op).
module alu_op_decoder
   import alu_seq_pkg::*;
#(
   parameter int CTRL_W = DEF_CTRL_W
)(
   input  logic [CTRL_W-1:0] opcode,
   output logic              legal
);

   always_comb begin
      legal = 1'b0;
      unique case (opcode)
         CTRL_W'(ALU_AND),
         CTRL_W'(ALU_OR),
         CTRL_W'(ALU_ADD),
         CTRL_W'(ALU_SUB),
         CTRL_W'(ALU_SLT),
         CTRL_W'(ALU_NOR): legal = 1'b1;
         default:          legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle regFile/ALU sequencer: one R-type op per 4 cycles.
// Ports: clk, reset_n (async, active-low); cmd_valid/cmd_ready handshake
// with cmd_opcode/dest/src1/src2; rf_read_addr0/1, rf_write_addr/data/en
// and alu_control to the datapath; alu_result/alu_zero from the ALU;
// done/err retire pulses and sticky zero_flag.
// Macro ALU_SEQ_PERF_CNT_EN adds retired_count[31:0] and err_count[15:0].
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CTRL_W       = DEF_CTRL_W,
   parameter bit R0_HARDWIRED = 1'b1
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CTRL_W-1:0] cmd_opcode,
   input  logic [ADDR_W-1:0] cmd_dest,
   input  logic [ADDR_W-1:0] cmd_src1,
   input  logic [ADDR_W-1:0] cmd_src2,
   output logic [ADDR_W-1:0] rf_read_addr0,
   output logic [ADDR_W-1:0] rf_read_addr1,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_write_en,
   output logic [CTRL_W-1:0] alu_control,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              done,
   output logic              err,
   output logic              zero_flag
`ifdef ALU_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]       retired_count,
   output logic [15:0]       err_count
`endif
);

   state_t            state;
   logic [ADDR_W-1:0] dest_q;
   logic              zero_q;
   logic              legal;
   logic              accept;

   alu_op_decoder #(
      .CTRL_W (CTRL_W)
   ) u_dec (
      .opcode (cmd_opcode),
      .legal  (legal)
   );

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Read addresses and alu_control are loaded at the accept edge so
   // they are already stable throughout READ and EXEC.
   // rf_write_data doubles as the captured ALU result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         dest_q        <= '0;
         zero_q        <= 1'b0;
         rf_read_addr0 <= '0;
         rf_read_addr1 <= '0;
         rf_write_addr <= '0;
         rf_write_data <= '0;
         rf_write_en   <= 1'b0;
         alu_control   <= '0;
         done          <= 1'b0;
         err           <= 1'b0;
         zero_flag     <= 1'b0;
      end else begin
         done        <= 1'b0;
         err         <= 1'b0;
         rf_write_en <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  dest_q <= cmd_dest;
                  if (legal) begin
                     rf_read_addr0 <= cmd_src1;
                     rf_read_addr1 <= cmd_src2;
                     alu_control   <= cmd_opcode;
                     state         <= READ;
                  end else begin
                     done  <= 1'b1;
                     err   <= 1'b1;
                     state <= ERR;
                  end
               end
            end
            READ: state <= EXEC;
            EXEC: begin
               rf_write_addr <= dest_q;
               rf_write_data <= alu_result;
               zero_q        <= alu_zero;
               rf_write_en   <= !(R0_HARDWIRED && dest_q == '0);
               done          <= 1'b1;
               state         <= WRITE;
            end
            WRITE: begin
               zero_flag <= zero_q;
               state     <= IDLE;
            end
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retired_count <= '0;
         err_count     <= '0;
      end else begin
         if (done && !err)
            retired_count <= retired_count + 32'd1;
         if (err && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle controller that sequences the register-file/ALU datapath for one R-type operation at a time. Accepts a command (opcode, dest, src1, src2) over a valid/ready handshake. Drives regFile read/write addresses, write enable and write data, and ALUControl. Captures the ALU result and zero flag, then performs write-back. Sits between the instruction front end and the regFile + ALU pair, replacing the hard-wired ADD / always-write arrangement.

Parameters:
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, datapath width
CTRL_W, 4, ALUControl width
R0_HARDWIRED, 1, when 1 a write-back to register 0 is suppressed

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_opcode  input  CTRL_W  ALUControl code for the operation
cmd_dest  input  ADDR_W  destination register
cmd_src1  input  ADDR_W  source register 0
cmd_src2  input  ADDR_W  source register 1
rf_read_addr0  output  ADDR_W  to regFile readAddress0
rf_read_addr1  output  ADDR_W  to regFile readAddress1
rf_write_addr  output  ADDR_W  to regFile writeAddress
rf_write_data  output  DATA_W  to regFile writeData
rf_write_en  output  1  to regFile writeEnable
alu_control  output  CTRL_W  to ALU ALUControl
alu_result  input  DATA_W  from ALU DataOut
alu_zero  input  1  from ALU ZeroOut
done  output  1  one-cycle pulse: operation retired
err  output  1  one-cycle pulse with done: illegal opcode, nothing written
zero_flag  output  1  zero flag of the last retired legal operation (sticky until next retire)

Behaviour:
- Reset is asynchronous, active-low; clock is clk. On reset: state=IDLE; all address, data and control outputs are 0; done, err, rf_write_en and zero_flag are 0; cmd_ready=1.
- regFile reads and the ALU are combinational. The regFile writes on the rising clk edge when rf_write_en=1.
- Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR. All other codes are illegal.
- cmd_ready=1 only in IDLE. A transfer occurs on an edge where cmd_valid and cmd_ready are both 1. The opcode, dest, src1 and src2 are registered at that edge. cmd_* inputs are ignored outside IDLE.
- FSM states: IDLE, READ, EXEC, WRITE, ERR.
  - IDLE: on a legal accept, go to READ. On an illegal accept, go to ERR.
  - READ: drive rf_read_addr0/1 = src1/src2 and alu_control = opcode. Go to EXEC next cycle.
  - EXEC: hold the same addresses and control. At the end of the cycle, result_q <= alu_result and zero_q <= alu_zero. Go to WRITE.
  - WRITE: rf_write_addr = dest, rf_write_data = result_q, rf_write_en = 1, done = 1, zero_flag <= zero_q. Go to IDLE.
  - If R0_HARDWIRED=1 and dest==0, rf_write_en stays 0 in WRITE; done still pulses.
  - ERR: done = 1 and err = 1 for one cycle, rf_write_en = 0, zero_flag unchanged. Go to IDLE.
- Latency: accept at edge T0 → READ in cycle T0+1 → EXEC in T0+2 → WRITE/done in T0+3 → cmd_ready=1 in T0+4. Throughput is one operation per 4 cycles.
- Outside READ/EXEC, alu_control and the read addresses hold their last values. Outside WRITE, rf_write_en=0.
- Read-after-write: a command accepted in the cycle cmd_ready returns sees the already-written value, because the write completes at the end of WRITE, before READ.
- reset_n asserted mid-operation aborts the operation immediately. No write-back occurs, done does not pulse, and all outputs return to reset values.
- rf_write_en, done and err are registered outputs (glitch-free). cmd_ready is decoded from state.

Optional Feature:
Macro ALU_SEQ_PERF_CNT_EN.
- Defined: adds output retired_count [31:0] and output err_count [15:0].
  - retired_count increments on every done pulse with err=0.
  - err_count increments on every err pulse and saturates at 0xFFFF.
  - retired_count wraps at 2^32.
  - Both counters reset to 0 on reset_n.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package alu_seq_pkg holds:
  - the state enum (IDLE, READ, EXEC, WRITE, ERR);
  - ALUControl opcode constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR);
  - the ADDR_W/DATA_W/CTRL_W defaults.
- One sub-module, alu_op_decoder: combinational opcode → legal bit. It is reused by the front end.

Test Plan:
- Reset then idle → cmd_ready=1; done=0, rf_write_en=0, all addresses 0.
- Preload r1=5, r2=7; cmd ADD(0010) dest=3 src1=1 src2=2 accepted at T0 → rf_write_en=1 with addr 3 and data 12 at T0+3, done=1, zero_flag=0, cmd_ready=1 at T0+4.
- r4=r5=9; SUB(0110) dest=6 src1=4 src2=5 → write 0 to r6, zero_flag=1. Then immediately ADD dest=7 src1=6 src2=1 → r7=5 (proves read-after-write).
- Opcode 1111 dest=8 → done=1 and err=1 at T0+1, no write cycle, r8 unchanged. With ALU_SEQ_PERF_CNT_EN, err_count=1 and retired_count unchanged.
- ADD dest=0 with R0_HARDWIRED=1 → done pulses, rf_write_en never 1. Second cmd_valid held during busy cycles → accepted only at T0+4.
- reset_n pulled low during EXEC → no write, done stays 0, state IDLE. After release, a new ADD completes normally.
